// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - sequential shift-add WIDTH x WIDTH multiplier with valid/ready handshakes
// Optional signed operand support: define SEQ_MULT_SIGNED_EN.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] c
`ifdef SEQ_MULT_SIGNED_EN
    ,
    input  logic               signed_i
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   prod_lo;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     acc_sum;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg;
    logic               neg_nx;
    logic [2*WIDTH-1:0] product;
    logic               calc_done;

`ifdef SEQ_MULT_SIGNED_EN
    // Signed operands run through the unsigned core as magnitudes; the sign is reapplied at the output.
    always_comb begin
        a_mag  = (signed_i && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag  = (signed_i && b[WIDTH-1]) ? (~b + 1'b1) : b;
        neg_nx = signed_i & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
`else
    always_comb begin
        a_mag  = a;
        b_mag  = b;
        neg_nx = 1'b0;
    end
`endif

    // The add result is one bit wider than the stored accumulator; that carry is shifted straight back in.
    assign acc_sum   = {1'b0, acc} + (prod_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign calc_done = (cnt == CW'(WIDTH));
    assign product   = {acc, prod_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = CALC;
                end
            end
            CALC: begin
                if (calc_done) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            prod_lo <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand   <= a_mag;
                        prod_lo <= b_mag;
                        acc     <= '0;
                        cnt     <= '0;
                        neg     <= neg_nx;
                    end
                end
                CALC: begin
                    if (!calc_done) begin
                        {acc, prod_lo} <= {acc_sum, prod_lo[WIDTH-1:1]};
                        cnt            <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        c = '0;
        if (state == DONE) begin
            c = neg ? (~product + 1'b1) : product;
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - self-checking bench for seq_shift_add_multiplier (WIDTH=4 directed, WIDTH=8 random)
module tb_seq_shift_add_multiplier;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       iv4, ir4, ov4, or4, sg4;
    logic [3:0] a4, b4;
    logic [7:0] c4;
    logic       iv8, ir8, ov8, or8, sg8;
    logic [7:0] a8, b8;
    logic [15:0] c8;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    seq_shift_add_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4), .c(c4)
`ifdef SEQ_MULT_SIGNED_EN
        , .signed_i(sg4)
`endif
    );

    seq_shift_add_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .c(c8)
`ifdef SEQ_MULT_SIGNED_EN
        , .signed_i(sg8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one operand pair to the WIDTH=4 unit and wait for its product; lat counts edges after accept.
    task automatic mul4(input logic [3:0] a, input logic [3:0] b, input logic sg, input string tag,
                        output logic [7:0] res, output int lat);
        int w = 0;
        @(negedge clk);
        while (!ir4 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready_timeout"}, (w < 50), 1);
        iv4 = 1'b1; a4 = a; b4 = b; sg4 = sg;
        @(negedge clk);
        iv4 = 1'b0;
        check({tag, " in_ready_drop"}, ir4, 0);
        lat = 0;
        while (!ov4 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        res = c4;
    endtask

    task automatic drain4(input string tag);
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        check({tag, " out_valid_clear"}, ov4, 0);
    endtask

    logic [7:0]  r;
    logic [15:0] exp16;
    int          lat, ea, eb, acc_cyc, prev_cyc, w;

    initial begin
        rst_n = 1'b0;
        iv4 = 0; or4 = 0; sg4 = 0; a4 = 0; b4 = 0;
        iv8 = 0; or8 = 0; sg8 = 0; a8 = 0; b8 = 0;
        repeat (2) @(negedge clk);
        check("reset in_ready", ir4, 1);
        check("reset out_valid", ov4, 0);
        check("reset c", c4, 0);
        rst_n = 1'b1;

        // 1: max operands
        mul4(4'd15, 4'd15, 1'b0, "t1", r, lat);
        check("t1 latency", lat, 5);
        check("t1 c", r, 8'd225);
        drain4("t1");

        // 2: zero operands keep full latency
        mul4(4'd0, 4'd9, 1'b0, "t2a", r, lat);
        check("t2a latency", lat, 5);
        check("t2a c", r, 8'd0);
        drain4("t2a");
        mul4(4'd9, 4'd0, 1'b0, "t2b", r, lat);
        check("t2b latency", lat, 5);
        check("t2b c", r, 8'd0);
        drain4("t2b");

        // 3: backpressure holds result, new in_valid is not accepted
        mul4(4'd6, 4'd7, 1'b0, "t3", r, lat);
        check("t3 c", r, 8'd42);
        iv4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3 c_stable", c4, 8'd42);
            check("t3 out_valid_held", ov4, 1);
            check("t3 in_ready_low", ir4, 0);
        end
        iv4 = 1'b0;
        drain4("t3");

        // 4: reset mid-calculation aborts the operation
        @(negedge clk);
        iv4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
        @(negedge clk);
        iv4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4 out_valid", ov4, 0);
        check("t4 c", c4, 0);
        check("t4 in_ready", ir4, 1);
        @(negedge clk);
        rst_n = 1'b1;
        mul4(4'd3, 4'd5, 1'b0, "t4", r, lat);
        check("t4 next c", r, 8'd15);
        drain4("t4");

`ifdef SEQ_MULT_SIGNED_EN
        // 5: signed mode
        mul4(4'h8, 4'd7, 1'b1, "t5a", r, lat);
        check("t5a c", r, 8'hC8);
        check("t5a latency", lat, 5);
        drain4("t5a");
        mul4(4'h8, 4'h8, 1'b1, "t5b", r, lat);
        check("t5b c", r, 8'h40);
        drain4("t5b");
        mul4(4'd3, 4'hF, 1'b1, "t5c", r, lat);
        check("t5c c", r, 8'hFD);
        drain4("t5c");
        mul4(4'hF, 4'h2, 1'b0, "t5d", r, lat);
        check("t5d c", r, 8'd30);
        drain4("t5d");
`endif

        // 6: WIDTH=8 random back-to-back with garbage on the inputs while busy
        prev_cyc = -100;
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            w = 0;
            while (!ir8 && w < 50) begin
                @(negedge clk);
                w++;
            end
            check("t6 ready_timeout", (w < 50), 1);
            iv8 = 1'b1;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (k < 3) begin
                a8 = 8'hFF; b8 = (k == 0) ? 8'hFF : 8'h00;
            end
`ifdef SEQ_MULT_SIGNED_EN
            sg8 = 1'($urandom);
`endif
            ea = sg8 ? int'($signed(a8)) : int'(a8);
            eb = sg8 ? int'($signed(b8)) : int'(b8);
            exp16 = 16'(ea * eb);
            @(negedge clk);
            acc_cyc = cyc;
            check("t6 ii", (acc_cyc - prev_cyc >= 10), 1);
            prev_cyc = acc_cyc;
            lat = 0;
            while (!ov8 && lat < 60) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                sg8 = 1'($urandom) & sg8;
                @(negedge clk);
                lat++;
            end
            check("t6 latency", lat, 9);
            check("t6 c", c8, exp16);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("t6 c_hold", c8, exp16);
            or8 = 1'b1;
            @(negedge clk);
            or8 = 1'b0;
            check("t6 out_valid_clear", ov8, 0);
        end
        iv8 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
